// File: rtl/odo_rosc_sequencer.sv
// Stress/measure odometer sequencer for the three-chain HVT ring-oscillator block.
// Optional build macro ODO_AUTO_REPEAT_EN: restart the stress/measure cycle after every DONE.
module odo_rosc_sequencer #(
  parameter int CNT_W         = 16,
  parameter int STRESS_W      = 24,
  parameter int STRESS_CYCLES = 1000000,
  parameter int SETTLE_CYCLES = 8,
  parameter int GATE_CYCLES   = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             GO,
  input  logic             ABORT,
  input  logic             CFG_AC_DC,
  input  logic             CFG_EN_POWER,
  input  logic             ROSC_OUT,
  output logic             SEL_INV,
  output logic             SEL_NAND,
  output logic             SEL_NOR,
  output logic             START,
  output logic             AC_DC,
  output logic             EN_ROSC,
  output logic             MEAS_STRESS,
  output logic             EN_POWER_ROSC,
  output logic [CNT_W-1:0] CNT_DATA,
  output logic [1:0]       CNT_ID,
  output logic             CNT_VALID,
  input  logic             CNT_READY,
  output logic             BUSY,
  output logic             DONE
);

  localparam int TMR_W = STRESS_W;
  localparam logic SKIP_STRESS = (STRESS_CYCLES == 0);
  localparam logic [TMR_W-1:0] STRESS_LD = (STRESS_CYCLES > 0) ? TMR_W'(STRESS_CYCLES - 1) : '0;
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, STRESS, SETTLE, MEASURE, REPORT} state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [1:0]       idx;
  logic [CNT_W-1:0] edge_cnt;
  logic [2:0]       sel;
  logic             rosc_p0, rosc_p1, rosc_p2;
  logic             rise;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != '1)) return c + 1'b1;
    return c;
  endfunction

  function automatic logic [2:0] chain_sel(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  assign {SEL_NOR, SEL_NAND, SEL_INV} = sel;
  assign rise = rosc_p1 & ~rosc_p2;

  // Synchronizer stages p0/p1, edge-compare stage p2
  always_ff @(posedge CLK) begin
    if (RST) begin
      rosc_p0 <= 1'b0;
      rosc_p1 <= 1'b0;
      rosc_p2 <= 1'b0;
    end else begin
      rosc_p0 <= ROSC_OUT;
      rosc_p1 <= rosc_p0;
      rosc_p2 <= rosc_p1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || ABORT) begin
      state         <= IDLE;
      tmr           <= '0;
      idx           <= 2'd0;
      edge_cnt      <= '0;
      sel           <= 3'b000;
      START         <= 1'b0;
      AC_DC         <= 1'b0;
      EN_ROSC       <= 1'b0;
      MEAS_STRESS   <= 1'b0;
      EN_POWER_ROSC <= 1'b0;
      CNT_DATA      <= '0;
      CNT_ID        <= 2'd0;
      CNT_VALID     <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (GO) begin
            AC_DC         <= CFG_AC_DC;
            EN_POWER_ROSC <= CFG_EN_POWER;
            BUSY          <= 1'b1;
            MEAS_STRESS   <= 1'b1;
            idx           <= 2'd0;
            if (SKIP_STRESS) begin
              state   <= SETTLE;
              tmr     <= SETTLE_LD;
              EN_ROSC <= 1'b1;
              sel     <= 3'b001;
            end else begin
              state <= STRESS;
              tmr   <= STRESS_LD;
              START <= 1'b1;
            end
          end
        end
        STRESS: begin
          if (tmr == '0) begin
            state   <= SETTLE;
            tmr     <= SETTLE_LD;
            START   <= 1'b0;
            EN_ROSC <= 1'b1;
            sel     <= chain_sel(idx);
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        SETTLE: begin
          if (tmr == '0) begin
            state    <= MEASURE;
            tmr      <= GATE_LD;
            edge_cnt <= '0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        MEASURE: begin
          edge_cnt <= sat_inc(edge_cnt, rise);
          if (tmr == '0) begin
            state     <= REPORT;
            CNT_DATA  <= sat_inc(edge_cnt, rise);
            CNT_ID    <= idx;
            CNT_VALID <= 1'b1;
            EN_ROSC   <= 1'b0;
            sel       <= 3'b000;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        REPORT: begin
          if (CNT_READY) begin
            CNT_VALID <= 1'b0;
            if (idx != 2'd2) begin
              // Chains after the first are measured back-to-back without re-stress
              idx     <= 2'(idx + 2'd1);
              state   <= SETTLE;
              tmr     <= SETTLE_LD;
              EN_ROSC <= 1'b1;
              sel     <= chain_sel(2'(idx + 2'd1));
            end else begin
              DONE <= 1'b1;
`ifdef ODO_AUTO_REPEAT_EN
              idx <= 2'd0;
              if (SKIP_STRESS) begin
                state   <= SETTLE;
                tmr     <= SETTLE_LD;
                EN_ROSC <= 1'b1;
                sel     <= 3'b001;
              end else begin
                state <= STRESS;
                tmr   <= STRESS_LD;
                START <= 1'b1;
              end
`else
              state         <= IDLE;
              BUSY          <= 1'b0;
              MEAS_STRESS   <= 1'b0;
              AC_DC         <= 1'b0;
              EN_POWER_ROSC <= 1'b0;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_odo_rosc_sequencer.sv
// Directed, table-driven bench for odo_rosc_sequencer: nominal, saturating and no-stress builds.
module tb_odo_rosc_sequencer;

  typedef struct {
    int         hold;
    logic [1:0] exp_id;
    int         lo;
    int         hi;
    logic [2:0] exp_sel;
    int         exp_start;
    int         exp_en;
    logic       exp_done;
    logic       exp_acdc;
    logic       exp_enp;
  } report_vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ABORT = 1'b0;
  logic CFG_AC_DC = 1'b0;
  logic CFG_EN_POWER = 1'b0;
  logic CNT_READY = 1'b0;
  logic rosc = 1'b0;
  logic go_a = 1'b0, go_s = 1'b0, go_z = 1'b0;

  logic [2:0]  sel_a, sel_s, sel_z;
  logic        start_a, acdc_a, en_a, meas_a, enp_a, valid_a, busy_a, done_a;
  logic        start_s, acdc_s, en_s, meas_s, enp_s, valid_s, busy_s, done_s;
  logic        start_z, acdc_z, en_z, meas_z, enp_z, valid_z, busy_z, done_z;
  logic [15:0] data_a, data_z;
  logic [2:0]  data_s;
  logic [1:0]  id_a, id_s, id_z;

  int n_cmp = 0;
  int n_err = 0;
  int dut_sel = 0;
  int rosc_per = 4;
  int rph = 0;

  logic [2:0]  obs_sel;
  logic        obs_start, obs_acdc, obs_en, obs_meas, obs_enp, obs_valid, obs_busy, obs_done;
  logic [15:0] obs_data;
  logic [1:0]  obs_id;

  report_vec_t vec_a[3];
  report_vec_t vec_z[3];
  report_vec_t vec_s;

  always #5 CLK = ~CLK;

  odo_rosc_sequencer #(.CNT_W(16), .STRESS_W(24), .STRESS_CYCLES(8), .SETTLE_CYCLES(4), .GATE_CYCLES(16)) dut_a (
    .CLK(CLK), .RST(RST), .GO(go_a), .ABORT(ABORT), .CFG_AC_DC(CFG_AC_DC), .CFG_EN_POWER(CFG_EN_POWER),
    .ROSC_OUT(rosc), .SEL_INV(sel_a[0]), .SEL_NAND(sel_a[1]), .SEL_NOR(sel_a[2]), .START(start_a),
    .AC_DC(acdc_a), .EN_ROSC(en_a), .MEAS_STRESS(meas_a), .EN_POWER_ROSC(enp_a), .CNT_DATA(data_a),
    .CNT_ID(id_a), .CNT_VALID(valid_a), .CNT_READY(CNT_READY), .BUSY(busy_a), .DONE(done_a));

  odo_rosc_sequencer #(.CNT_W(3), .STRESS_W(24), .STRESS_CYCLES(0), .SETTLE_CYCLES(4), .GATE_CYCLES(64)) dut_s (
    .CLK(CLK), .RST(RST), .GO(go_s), .ABORT(ABORT), .CFG_AC_DC(CFG_AC_DC), .CFG_EN_POWER(CFG_EN_POWER),
    .ROSC_OUT(rosc), .SEL_INV(sel_s[0]), .SEL_NAND(sel_s[1]), .SEL_NOR(sel_s[2]), .START(start_s),
    .AC_DC(acdc_s), .EN_ROSC(en_s), .MEAS_STRESS(meas_s), .EN_POWER_ROSC(enp_s), .CNT_DATA(data_s),
    .CNT_ID(id_s), .CNT_VALID(valid_s), .CNT_READY(CNT_READY), .BUSY(busy_s), .DONE(done_s));

  odo_rosc_sequencer #(.CNT_W(16), .STRESS_W(24), .STRESS_CYCLES(0), .SETTLE_CYCLES(4), .GATE_CYCLES(16)) dut_z (
    .CLK(CLK), .RST(RST), .GO(go_z), .ABORT(ABORT), .CFG_AC_DC(CFG_AC_DC), .CFG_EN_POWER(CFG_EN_POWER),
    .ROSC_OUT(rosc), .SEL_INV(sel_z[0]), .SEL_NAND(sel_z[1]), .SEL_NOR(sel_z[2]), .START(start_z),
    .AC_DC(acdc_z), .EN_ROSC(en_z), .MEAS_STRESS(meas_z), .EN_POWER_ROSC(enp_z), .CNT_DATA(data_z),
    .CNT_ID(id_z), .CNT_VALID(valid_z), .CNT_READY(CNT_READY), .BUSY(busy_z), .DONE(done_z));

  // Oscillator model: square wave of rosc_per clock cycles, changing on the falling edge
  always @(negedge CLK) begin
    if (rph + 1 >= rosc_per) rph <= 0;
    else rph <= rph + 1;
    rosc <= (rph < rosc_per / 2);
  end

  always_comb begin
    obs_sel = sel_a; obs_start = start_a; obs_acdc = acdc_a; obs_en = en_a; obs_meas = meas_a;
    obs_enp = enp_a; obs_valid = valid_a; obs_busy = busy_a; obs_done = done_a;
    obs_data = data_a; obs_id = id_a;
    if (dut_sel == 1) begin
      obs_sel = sel_s; obs_start = start_s; obs_acdc = acdc_s; obs_en = en_s; obs_meas = meas_s;
      obs_enp = enp_s; obs_valid = valid_s; obs_busy = busy_s; obs_done = done_s;
      obs_data = {13'd0, data_s}; obs_id = id_s;
    end else if (dut_sel == 2) begin
      obs_sel = sel_z; obs_start = start_z; obs_acdc = acdc_z; obs_en = en_z; obs_meas = meas_z;
      obs_enp = enp_z; obs_valid = valid_z; obs_busy = busy_z; obs_done = done_z;
      obs_data = data_z; obs_id = id_z;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input logic [31:0] act, input int lo, input int hi);
    n_cmp++;
    if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic pulse_go();
    @(negedge CLK);
    if (dut_sel == 0) go_a = 1'b1; else if (dut_sel == 1) go_s = 1'b1; else go_z = 1'b1;
    @(negedge CLK);
    go_a = 1'b0; go_s = 1'b0; go_z = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
  endtask

  // Observe one chain from the current sample up to REPORT, then hold off READY and handshake
  task automatic run_vec(input string tag, input report_vec_t v);
    int cyc, st, enc, selbad, cfgbad, holdbad;
    logic [15:0] d0;
    logic [1:0]  i0;
    cyc = 0; st = 0; enc = 0; selbad = 0; cfgbad = 0; holdbad = 0;
    while (!obs_valid && cyc < 2000) begin
      if (obs_start) st++;
      if (obs_en) begin
        enc++;
        if (obs_sel !== v.exp_sel) selbad++;
      end
      if (obs_busy && (obs_acdc !== v.exp_acdc || obs_enp !== v.exp_enp)) cfgbad++;
      @(negedge CLK);
      cyc++;
    end
    chk({tag, "_valid_seen"}, obs_valid, 1);
    chk({tag, "_start_cycles"}, st, v.exp_start);
    chk({tag, "_en_cycles"}, enc, v.exp_en);
    chk({tag, "_sel_bad"}, selbad, 0);
    chk({tag, "_cfg_bad"}, cfgbad, 0);
    chk({tag, "_rep_sel"}, obs_sel, 0);
    chk({tag, "_id"}, obs_id, v.exp_id);
    chk_rng({tag, "_data"}, obs_data, v.lo, v.hi);
    d0 = obs_data;
    i0 = obs_id;
    if (v.hold > 0) begin
      for (int k = 0; k < v.hold; k++) begin
        @(negedge CLK);
        if (!obs_valid || obs_data !== d0 || obs_id !== i0) holdbad++;
      end
      chk({tag, "_hold_bad"}, holdbad, 0);
    end
    CNT_READY = 1'b1;
    @(negedge CLK);
    CNT_READY = 1'b0;
    chk({tag, "_valid_drop"}, obs_valid, 0);
    chk({tag, "_done"}, obs_done, v.exp_done);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    vec_a[0] = '{0,  2'd0, 3, 5, 3'b001, 8, 20, 1'b0, 1'b1, 1'b0};
    vec_a[1] = '{10, 2'd1, 3, 5, 3'b010, 0, 20, 1'b0, 1'b1, 1'b0};
    vec_a[2] = '{0,  2'd2, 3, 5, 3'b100, 0, 20, 1'b1, 1'b1, 1'b0};
    vec_z[0] = '{0,  2'd0, 3, 5, 3'b001, 0, 20, 1'b0, 1'b0, 1'b1};
    vec_z[1] = '{0,  2'd1, 3, 5, 3'b010, 0, 20, 1'b0, 1'b0, 1'b1};
    vec_z[2] = '{0,  2'd2, 3, 5, 3'b100, 0, 20, 1'b1, 1'b0, 1'b1};
    vec_s    = '{0,  2'd0, 7, 7, 3'b001, 0, 68, 1'b0, 1'b1, 1'b0};

    // Reset state
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_sel", sel_a, 0);
    chk("rst_start", start_a, 0);
    chk("rst_acdc", acdc_a, 0);
    chk("rst_en", en_a, 0);
    chk("rst_meas", meas_a, 0);
    chk("rst_enp", enp_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_id", id_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_busy_z", busy_z, 0);
    RST = 1'b0;
    @(negedge CLK);

    // GO and ABORT together: ABORT wins
    dut_sel = 0;
    @(negedge CLK);
    go_a = 1'b1; ABORT = 1'b1;
    @(negedge CLK);
    go_a = 1'b0; ABORT = 1'b0;
    chk("goabort_busy", busy_a, 0);
    chk("goabort_start", start_a, 0);

    // Nominal run with backpressure on the NAND report
    CFG_AC_DC = 1'b1; CFG_EN_POWER = 1'b0; rosc_per = 4;
    pulse_go();
    for (int i = 0; i < 3; i++) run_vec($sformatf("nom%0d", i), vec_a[i]);
    @(negedge CLK);
    chk("nom_done_width", done_a, 0);
`ifdef ODO_AUTO_REPEAT_EN
    chk("nom_repeat_busy", busy_a, 1);
    pulse_abort();
`else
    chk("nom_end_busy", busy_a, 0);
    chk("nom_end_acdc", acdc_a, 0);
`endif

    // Abort in MEASURE of the NAND chain
    pulse_go();
    run_vec("abt0", vec_a[0]);
    repeat (9) @(negedge CLK);
    chk("abt_pre_en", en_a, 1);
    chk("abt_pre_sel", sel_a, 3'b010);
    pulse_abort();
    chk("abt_en", en_a, 0);
    chk("abt_sel", sel_a, 0);
    chk("abt_valid", valid_a, 0);
    chk("abt_busy", busy_a, 0);
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (done_a) dcnt++;
      @(negedge CLK);
    end
    chk("abt_no_done", dcnt, 0);
    pulse_go();
    run_vec("abt_restart", vec_a[0]);
    pulse_abort();

    // Saturation with a 3-bit counter
    dut_sel = 1; rosc_per = 8;
    pulse_go();
    run_vec("sat", vec_s);
    pulse_abort();
    chk("sat_busy", busy_s, 0);

    // No-stress build, with optional automatic repetition
    dut_sel = 2; rosc_per = 4; CFG_AC_DC = 1'b0; CFG_EN_POWER = 1'b1;
    pulse_go();
    for (int i = 0; i < 3; i++) run_vec($sformatf("zs%0d", i), vec_z[i]);
`ifdef ODO_AUTO_REPEAT_EN
    chk("zs_repeat_busy", busy_z, 1);
    for (int i = 0; i < 3; i++) run_vec($sformatf("zr%0d", i), vec_z[i]);
    pulse_abort();
    chk("zr_abort_busy", busy_z, 0);
`else
    @(negedge CLK);
    chk("zs_end_busy", busy_z, 0);
    chk("zs_end_enp", enp_z, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
